// File: rtl/i2c_eddc_slave.sv
// E-DDC I2C target serving a multi-segment EDID image from a dual-port RAM, with a host patch port.
// SCL/SDA are synchronised and glitch-filtered; SDA drive changes one clk after the filtered SCL fall.
module i2c_eddc_slave #(
    parameter logic [6:0] DEV_ADDR    = 7'h50,
    parameter logic [6:0] SEG_ADDR    = 7'h30,
    parameter int         NUM_SEG     = 2,
    parameter bit         I2C_WR_EN   = 1'b0,
    parameter int         SYNC_STAGES = 2,
    parameter int         FILTER_LEN  = 3,
    localparam int        DEPTH       = NUM_SEG * 256,
    localparam int        AW          = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          scl_i,
    input  logic          sda_i,
    output logic          sda_oe,
    input  logic          cfg_we,
    input  logic [AW-1:0] cfg_addr,
    input  logic [7:0]    cfg_wdata,
    output logic [7:0]    cfg_rdata,
    output logic          busy,
    output logic          xfer_done,
    output logic [6:0]    seg_o
);
    localparam int CW = $clog2(FILTER_LEN) + 1;
    localparam logic [CW-1:0] FLT_MAX = CW'(FILTER_LEN - 1);

    typedef enum logic [3:0] {
        IDLE, ADDR, ACK_ADDR, SEG_RX, ACK_SEG, OFF_RX, ACK_OFF, WR_RX, ACK_WR, TX, RX_ACK
    } state_t;

    logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
    logic [CW-1:0]          scl_cnt_q, sda_cnt_q;
    logic                   scl_f_q, sda_f_q, scl_prev_q, sda_prev_q;
    logic                   scl_s, sda_s;

    assign scl_s = scl_sync_q[SYNC_STAGES-1];
    assign sda_s = sda_sync_q[SYNC_STAGES-1];

    // Bus idles high, so the input path resets high to avoid a phantom edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_cnt_q  <= '0;
            sda_cnt_q  <= '0;
            scl_f_q    <= 1'b1;
            sda_f_q    <= 1'b1;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_i};
            sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_i};
            scl_prev_q <= scl_f_q;
            sda_prev_q <= sda_f_q;
            if (scl_s == scl_f_q) begin
                scl_cnt_q <= '0;
            end else if (scl_cnt_q == FLT_MAX) begin
                scl_f_q   <= scl_s;
                scl_cnt_q <= '0;
            end else begin
                scl_cnt_q <= scl_cnt_q + CW'(1);
            end
            if (sda_s == sda_f_q) begin
                sda_cnt_q <= '0;
            end else if (sda_cnt_q == FLT_MAX) begin
                sda_f_q   <= sda_s;
                sda_cnt_q <= '0;
            end else begin
                sda_cnt_q <= sda_cnt_q + CW'(1);
            end
        end
    end

    logic scl_rise, scl_fall, start_det, stop_det;
    assign scl_rise  = scl_f_q & ~scl_prev_q;
    assign scl_fall  = ~scl_f_q & scl_prev_q;
    assign start_det = scl_f_q & scl_prev_q & sda_prev_q & ~sda_f_q;
    assign stop_det  = scl_f_q & scl_prev_q & ~sda_prev_q & sda_f_q;

    state_t     state_q, state_d, nxt_q, nxt_d;
    logic [2:0] bit_q, bit_d;
    logic       done_q, done_d;
    logic [7:0] sh_q, sh_d;
    logic [6:0] seg_q, seg_d;
    logic [7:0] off_q, off_d;
    logic       oe_q, oe_d, busy_q, busy_d, xfer_q, xfer_d;
    logic       ram_we, seg_ok, rx_state;
    logic [7:0] ram_rd_q, tx_byte;
    logic [AW-1:0] i2c_addr;
    logic [7:0] mem [DEPTH];

    assign i2c_addr = AW'({seg_q, off_q});
    assign seg_ok   = ({1'b0, seg_q} < 8'(NUM_SEG));
    assign tx_byte  = seg_ok ? ram_rd_q : 8'hFF;
    assign rx_state = (state_q == ADDR) || (state_q == SEG_RX) ||
                      (state_q == OFF_RX) || (state_q == WR_RX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            nxt_q   <= IDLE;
            bit_q   <= 3'd7;
            done_q  <= 1'b0;
            sh_q    <= '0;
            seg_q   <= '0;
            off_q   <= '0;
            oe_q    <= 1'b0;
            busy_q  <= 1'b0;
            xfer_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            nxt_q   <= nxt_d;
            bit_q   <= bit_d;
            done_q  <= done_d;
            sh_q    <= sh_d;
            seg_q   <= seg_d;
            off_q   <= off_d;
            oe_q    <= oe_d;
            busy_q  <= busy_d;
            xfer_q  <= xfer_d;
        end
    end

    always_comb begin
        state_d = state_q;
        nxt_d   = nxt_q;
        bit_d   = bit_q;
        done_d  = done_q;
        sh_d    = sh_q;
        seg_d   = seg_q;
        off_d   = off_q;
        oe_d    = oe_q;
        busy_d  = busy_q;
        xfer_d  = 1'b0;
        ram_we  = 1'b0;
        if (stop_det) begin
            state_d = IDLE;
            oe_d    = 1'b0;
            seg_d   = '0;
            xfer_d  = busy_q;
            busy_d  = 1'b0;
        end else if (start_det) begin
            state_d = ADDR;
            bit_d   = 3'd7;
            done_d  = 1'b0;
            oe_d    = 1'b0;
        end else begin
            if (rx_state && scl_rise && !done_q) begin
                sh_d = {sh_q[6:0], sda_f_q};
                if (bit_q == 3'd0) done_d = 1'b1;
                else               bit_d  = bit_q - 3'd1;
            end
            // Byte-complete decisions and ACK windows all act on SCL fall.
            if (scl_fall) begin
                case (state_q)
                    ADDR, SEG_RX, OFF_RX, WR_RX: begin
                        if (done_q) begin
                            done_d = 1'b0;
                            bit_d  = 3'd7;
                            if (state_q == ADDR) begin
                                if (sh_q == {SEG_ADDR, 1'b0} || sh_q == {DEV_ADDR, 1'b0} ||
                                    sh_q == {DEV_ADDR, 1'b1}) begin
                                    oe_d    = 1'b1;
                                    busy_d  = 1'b1;
                                    state_d = ACK_ADDR;
                                    nxt_d   = (sh_q == {SEG_ADDR, 1'b0}) ? SEG_RX :
                                              (sh_q[0] ? TX : OFF_RX);
                                end else begin
                                    state_d = IDLE;
                                end
                            end else if (state_q == SEG_RX) begin
                                seg_d   = sh_q[6:0];
                                oe_d    = 1'b1;
                                state_d = ACK_SEG;
                            end else if (state_q == OFF_RX) begin
                                off_d   = sh_q;
                                oe_d    = 1'b1;
                                state_d = ACK_OFF;
                            end else if (I2C_WR_EN) begin
                                ram_we  = seg_ok;
                                off_d   = off_q + 8'd1;
                                oe_d    = 1'b1;
                                state_d = ACK_WR;
                            end else begin
                                state_d = IDLE;
                            end
                        end
                    end
                    ACK_ADDR: begin
                        if (nxt_q == TX) begin
                            sh_d    = tx_byte;
                            oe_d    = ~tx_byte[7];
                            bit_d   = 3'd7;
                            state_d = TX;
                        end else begin
                            oe_d    = 1'b0;
                            state_d = nxt_q;
                        end
                    end
                    ACK_SEG: begin
                        oe_d    = 1'b0;
                        state_d = IDLE;
                    end
                    ACK_OFF, ACK_WR: begin
                        oe_d    = 1'b0;
                        state_d = WR_RX;
                    end
                    TX: begin
                        if (bit_q == 3'd0) begin
                            oe_d    = 1'b0;
                            done_d  = 1'b0;
                            state_d = RX_ACK;
                        end else begin
                            sh_d  = {sh_q[6:0], 1'b0};
                            oe_d  = ~sh_q[6];
                            bit_d = bit_q - 3'd1;
                        end
                    end
                    RX_ACK: begin
                        if (done_q) begin
                            done_d  = 1'b0;
                            sh_d    = tx_byte;
                            oe_d    = ~tx_byte[7];
                            bit_d   = 3'd7;
                            state_d = TX;
                        end
                    end
                    default: ;
                endcase
            end else if (scl_rise && state_q == RX_ACK && !done_q) begin
                if (sda_f_q) begin
                    state_d = IDLE;
                end else begin
                    off_d  = off_q + 8'd1;
                    done_d = 1'b1;
                end
            end
        end
    end

    // Host write wins a same-address collision; the in-flight TX byte lives in sh_q.
    always_ff @(posedge clk) begin
        if (ram_we && !(cfg_we && cfg_addr == i2c_addr)) mem[i2c_addr] <= sh_q;
        if (cfg_we) mem[cfg_addr] <= cfg_wdata;
        ram_rd_q <= mem[i2c_addr];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cfg_rdata <= '0;
        else        cfg_rdata <= mem[cfg_addr];
    end

    assign sda_oe    = oe_q;
    assign busy      = busy_q;
    assign xfer_done = xfer_q;
    assign seg_o     = seg_q;
endmodule

// File: doc/i2c_eddc_slave.md
# i2c_eddc_slave

Parametrised E-DDC (Enhanced DDC) I2C target that serves a multi-segment EDID image from internal dual-port RAM. It answers the EDID address (default 0x50) and the segment-pointer address (default 0x30), auto-increments the word offset, and optionally accepts I2C writes. A host-side port loads or patches the image at runtime. It sits between the DVI/HDMI DDC pins and the system configuration bus in the DVI-to-LVDS bridge.

## Interface
- DEV_ADDR, 7'h50, 7-bit EDID target address
- SEG_ADDR, 7'h30, 7-bit segment-pointer address
- NUM_SEG, 2, number of 256-byte segments (1..128); RAM depth = NUM_SEG*256
- I2C_WR_EN, 0, 1 = I2C writes to DEV_ADDR stored and ACKed; 0 = data bytes NACKed
- SYNC_STAGES, 2, input synchroniser depth (>=2)
- FILTER_LEN, 3, consecutive equal samples needed to accept an SCL/SDA level (>=1)

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- scl_i  in  1  I2C clock from pad
- sda_i  in  1  I2C data from pad
- sda_oe  out  1  1 = drive SDA low; 0 = release (pad is open-drain)
- cfg_we  in  1  host write strobe
- cfg_addr  in  $clog2(NUM_SEG*256)  host byte address
- cfg_wdata  in  8  host write data
- cfg_rdata  out  8  host read data, 1-cycle latency from cfg_addr
- busy  out  1  high while a transaction addressed to this block is in progress
- xfer_done  out  1  one-cycle pulse on STOP ending an addressed transaction
- seg_o  out  7  current segment pointer

## Operation
- Input path: scl_i/sda_i pass SYNC_STAGES flops, then a filter; filtered level changes only after FILTER_LEN identical samples. Edges, START (SDA fall, SCL high), STOP (SDA rise, SCL high) derive from filtered levels.
- States: IDLE, ADDR, ACK_ADDR, SEG_RX, ACK_SEG, OFF_RX, ACK_OFF, WR_RX, ACK_WR, TX, RX_ACK.
- START in any state: -> ADDR, bit count 7, sda_oe=0. Repeated START keeps seg and offset.
- STOP in any state: -> IDLE, sda_oe=0, seg reset to 0 (E-DDC rule), xfer_done pulses if busy was high, busy falls.
- ADDR: sample 8 bits on SCL rise, MSB first. Match rules:
  - {SEG_ADDR,W}: ACK -> SEG_RX.
  - {DEV_ADDR,W}: ACK -> OFF_RX.
  - {DEV_ADDR,R}: ACK -> TX.
  - Anything else, including {SEG_ADDR,R}: no ACK, -> IDLE.
- ACK states: on the SCL fall ending bit 8, assert sda_oe. On the next SCL fall, release it or drive TX bit 7.
- SEG_RX: receive byte, ACK; seg <= byte[6:0]. -> IDLE (waits for repeated START).
- OFF_RX: receive byte, ACK; offset <= byte. -> WR_RX.
- WR_RX: receive byte.
  - If I2C_WR_EN: RAM[{seg,offset}] <= byte, offset+1, ACK, stay in write loop.
  - Else: no ACK, -> IDLE.
- TX: on ACK/RX_ACK exit fall, load RAM data and drive bit 7; bits 6..0 shift out on each SCL fall. After bit 0's fall, release -> RX_ACK.
- RX_ACK: sample on SCL rise.
  - 0 (ACK): offset+1, -> TX.
  - 1 (NACK): -> IDLE, busy stays high until STOP.
- Offset is 8 bits and wraps 0xFF->0x00 within the segment; seg never auto-increments.
- seg >= NUM_SEG: reads return 0xFF, writes discarded, but still ACKed.
- RAM: I2C port address {seg,offset}; read is synchronous and prefetched. Data for the next byte is valid before the SCL fall that needs it.
- Host port: independent. If the host and I2C write the same address in the same cycle, the host wins. A host write to the byte currently being shifted does not alter the in-flight byte.
- busy rises on an address match ACK.

## Timing
- Reset values: sda_oe=0, busy=0, xfer_done=0, seg_o=0, offset=0, cfg_rdata=0, state IDLE. RAM contents undefined (loaded by host).
- Detect latency: SYNC_STAGES+FILTER_LEN clk cycles from pad edge to internal edge.
- sda_oe updates 1 clk after the internal SCL-fall edge, so SDA hold > 0 at the pad.
- Constraint: (SYNC_STAGES+FILTER_LEN+2)*Tclk < tLOW - tSU;DAT. At 50 MHz with defaults, 400 kHz is met.
- xfer_done is 1 clk wide, coincident with busy falling.
- Async reset mid-transfer releases SDA immediately; the bus recovers at the next START.

## Test plan
- Host loads RAM[i]=i^0x5A. I2C writes offset 0x10 to 0x50, repeated START, reads 4 bytes then NACK -> bytes 0x4A,0x4B,0x48,0x49; all ACKs correct; xfer_done on STOP.
- Write seg=1 to 0x30; offset 0xFE to 0x50; read 3 bytes -> RAM[0x1FE],RAM[0x1FF],RAM[0x100] (wrap). After STOP, seg_o=0.
- NUM_SEG=2, seg=5, read 1 byte -> 0xFF. Read from 0x30 -> address NACKed, sda_oe never asserted.
- I2C_WR_EN=0: write 0xAA at offset 0x20 -> data byte NACKed, RAM unchanged. I2C_WR_EN=1 -> ACKed, cfg_rdata=0xAA at 0x020.
- Address 0x51 -> no ACK, busy stays 0. A 1-sample SDA glitch with SCL high (FILTER_LEN=3) -> no START/STOP detected.
- rst_n asserted mid-TX while driving 0 -> sda_oe=0 next edge. A new START then works normally.
